// File: rtl/otter_dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otter_dmem_arb_pkg
//  Description : Shared types and constants for the OTTER data-memory
//                port-2 arbiter (owner tags, arbiter states, access sizes).
//  Revision    : 1.0 - initial release
// ============================================================================
package otter_dmem_arb_pkg;

    // Which requester a read issued last cycle belongs to
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    // Arbiter states; LOCKED only exists when the burst-lock build is enabled
    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Access size encodings carried on the size fields
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/otter_dmem_starve_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : otter_dmem_starve_ctr
//  Description : Saturating counter of consecutive denied DMA cycles.
//                at_limit is high once the count equals STARVE_LIMIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_dmem_starve_ctr
    import otter_dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    // Clear has priority over increment; the count sticks at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (clr) begin
            starve_cnt <= '0;
        end else if (inc && (starve_cnt != LIMIT_VAL)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign at_limit = (starve_cnt == LIMIT_VAL);

endmodule
`default_nettype wire

// File: rtl/otter_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : otter_dmem_arbiter
//  Description : Arbitrates OTTER memory data port 2 between the CPU MEM
//                stage and a DMA requester. CPU has fixed priority, a
//                starvation counter forces a DMA grant after STARVE_LIMIT
//                denied cycles, and read data is routed back by owner tag.
//                Optional DMA burst lock: define OTTER_DMEM_ARB_LOCK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_dmem_arbiter
    import otter_dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int LOCK_MAX     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    // CPU (MEM stage) requester
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sign,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    // DMA / programmer requester
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_size,
    input  logic        dma_sign,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
`ifdef OTTER_DMEM_ARB_LOCK_EN
    input  logic        dma_lock,
`endif
    // Memory port 2
    output logic        mem_read2,
    output logic        mem_write2,
    output logic [31:0] mem_addr2,
    output logic [31:0] mem_din2,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_dout2
);

    // Elaboration-time parameter range checks
    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_starve_limit
        $error("otter_dmem_arbiter: STARVE_LIMIT must be in 1..255");
    end
    if (LOCK_MAX < 1) begin : g_bad_lock_max
        $error("otter_dmem_arbiter: LOCK_MAX must be at least 1");
    end

    logic   at_limit;
    logic   force_dma;
    logic   locked_now;
    logic   starve_inc;
    logic   starve_clr;
    owner_e owner;

`ifdef OTTER_DMEM_ARB_LOCK_EN
    localparam int LOCK_W = $clog2(LOCK_MAX + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX_VAL = LOCK_W'(LOCK_MAX);

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [LOCK_W-1:0] lock_cnt;
    logic [LOCK_W-1:0] lock_cnt_nxt;
    logic              lock_block;
    logic              lock_block_nxt;

    // The lock only holds while requested and the burst budget remains;
    // otherwise this cycle is arbitrated normally.
    assign locked_now = (state == LOCKED) && dma_lock && (lock_cnt != LOCK_MAX_VAL);

    // Lock FSM state, burst counter and post-forced-exit lock suppression
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB;
            lock_cnt   <= '0;
            lock_block <= 1'b0;
        end else begin
            state      <= state_nxt;
            lock_cnt   <= lock_cnt_nxt;
            lock_block <= lock_block_nxt;
        end
    end

    // Lock FSM next state: enter on a locked DMA grant, leave on release or budget
    always_comb begin
        state_nxt      = state;
        lock_cnt_nxt   = lock_cnt;
        lock_block_nxt = lock_block;
        if (!dma_lock) begin
            lock_block_nxt = 1'b0;
        end
        case (state)
            ARB: begin
                if (dma_gnt && dma_lock && !lock_block) begin
                    state_nxt    = LOCKED;
                    lock_cnt_nxt = '0;
                end
            end
            LOCKED: begin
                if (locked_now) begin
                    if (dma_req) begin
                        lock_cnt_nxt = lock_cnt + 1'b1;
                    end
                end else begin
                    state_nxt = ARB;
                    // A forced exit ignores DMA_LOCK until it is dropped
                    if (dma_lock) begin
                        lock_block_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ARB;
        endcase
    end
`else
    assign locked_now = 1'b0;
`endif

    assign force_dma = dma_req & at_limit;

    // Grant selection; everything is held off while reset is asserted
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (rst_n) begin
            if (locked_now) begin
                dma_gnt = dma_req;
            end else if (force_dma) begin
                dma_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else begin
                dma_gnt = dma_req;
            end
        end
    end

    assign starve_inc = dma_req & ~dma_gnt & ~locked_now;
    assign starve_clr = dma_gnt | ~dma_req | locked_now;

    otter_dmem_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .at_limit (at_limit)
    );

    // Memory-side mux: DMA fields only when DMA holds the grant, else CPU
    always_comb begin
        mem_read2  = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
        mem_write2 = (cpu_gnt &  cpu_we) | (dma_gnt &  dma_we);
        mem_addr2  = cpu_addr;
        mem_din2   = cpu_wdata;
        mem_size   = cpu_size;
        mem_sign   = cpu_sign;
        if (dma_gnt) begin
            mem_addr2 = dma_addr;
            mem_din2  = dma_wdata;
            mem_size  = dma_size;
            mem_sign  = dma_sign;
        end
    end

    // Owner tag of the read issued this cycle, consumed when data returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= OWN_NONE;
        end else if (cpu_gnt && !cpu_we) begin
            owner <= OWN_CPU;
        end else if (dma_gnt && !dma_we) begin
            owner <= OWN_DMA;
        end else begin
            owner <= OWN_NONE;
        end
    end

    assign cpu_rvalid = (owner == OWN_CPU);
    assign dma_rvalid = (owner == OWN_DMA);
    assign cpu_rdata  = mem_dout2;
    assign dma_rdata  = mem_dout2;

endmodule
`default_nettype wire

// File: tb/tb_otter_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_otter_dmem_arbiter
//  Description : Self-checking bench for otter_dmem_arbiter: directed cases
//                followed by random CPU/DMA traffic against a byte-level
//                reference memory and grant-rule model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_sign;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we, dma_sign;
    logic [31:0] dma_addr, dma_wdata;
    logic [1:0]  dma_size;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
`ifdef OTTER_DMEM_ARB_LOCK_EN
    logic        dma_lock = 1'b0;
`endif
    logic        mem_read2, mem_write2, mem_sign;
    logic [31:0] mem_addr2, mem_din2;
    logic [1:0]  mem_size;
    logic [31:0] mem_dout2;

    logic        mem_init;
    logic [31:0] mem_arr [0:255];
    logic [7:0]  ref_bytes [0:1023];
    int          dma_wait;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        g_cpu, g_dma, obs_cpu_gnt, obs_dma_gnt;

    always #5 clk = ~clk;

    otter_dmem_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .LOCK_MAX     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_size   (cpu_size),
        .cpu_sign   (cpu_sign),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_size   (dma_size),
        .dma_sign   (dma_sign),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
`ifdef OTTER_DMEM_ARB_LOCK_EN
        .dma_lock   (dma_lock),
`endif
        .mem_read2  (mem_read2),
        .mem_write2 (mem_write2),
        .mem_addr2  (mem_addr2),
        .mem_din2   (mem_din2),
        .mem_size   (mem_size),
        .mem_sign   (mem_sign),
        .mem_dout2  (mem_dout2)
    );

    // Initial memory contents; word 0x100 holds 0x12345678
    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        if (i == 64) return 32'h12345678;
        return {8'hA5 ^ b, b, ~b, 8'h3C ^ b};
    endfunction

    // Memory behind port 2: byte/half/word stores, one-cycle read latency
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
        end else begin
            if (mem_write2) begin
                case (mem_size)
                    2'd0:    mem_arr[mem_addr2[9:2]][{mem_addr2[1:0], 3'b000} +: 8] <= mem_din2[7:0];
                    2'd1:    mem_arr[mem_addr2[9:2]][{mem_addr2[1], 4'b0000} +: 16] <= mem_din2[15:0];
                    default: mem_arr[mem_addr2[9:2]] <= mem_din2;
                endcase
            end
            if (mem_read2) mem_dout2 <= mem_arr[mem_addr2[9:2]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'(a[9:2]) * 4;
        return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int base;
        int n;
        base = int'(a[9:0]);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_bytes[base + k] = d[8*k +: 8];
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] s, input logic sg);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d; cpu_size = s; cpu_sign = sg;
    endtask

    task automatic set_dma(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] s, input logic sg);
        dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d; dma_size = s; dma_sign = sg;
    endtask

    // One cycle: inputs are already driven just after a falling edge.
    // Checks grants and the memory-side mux, updates the model, then
    // checks the read return one cycle later at the next falling edge.
    task automatic step();
        logic        e_cpu, e_dma, e_rd, e_wr, e_sg;
        logic [31:0] e_addr, e_din, e_data;
        logic [1:0]  e_sz;
        int          own;
        #1;
        e_dma = dma_req && (!cpu_req || (dma_wait == LIMIT));
        e_cpu = cpu_req && !e_dma;
        e_rd  = (e_cpu && !cpu_we) || (e_dma && !dma_we);
        e_wr  = (e_cpu && cpu_we) || (e_dma && dma_we);
        e_addr = e_dma ? dma_addr  : cpu_addr;
        e_din  = e_dma ? dma_wdata : cpu_wdata;
        e_sz   = e_dma ? dma_size  : cpu_size;
        e_sg   = e_dma ? dma_sign  : cpu_sign;
        obs_cpu_gnt = cpu_gnt;
        obs_dma_gnt = dma_gnt;
        check_eq("cpu_gnt", cpu_gnt, e_cpu);
        check_eq("dma_gnt", dma_gnt, e_dma);
        check_eq("mem_read2", mem_read2, e_rd);
        check_eq("mem_write2", mem_write2, e_wr);
        check_eq("mem_addr2", mem_addr2, e_addr);
        check_eq("mem_din2", mem_din2, e_din);
        check_eq("mem_size_sign", {mem_size, mem_sign}, {e_sz, e_sg});
        g_cpu = e_cpu;
        g_dma = e_dma;
        if (dma_req && !e_dma) dma_wait = (dma_wait < LIMIT) ? dma_wait + 1 : LIMIT;
        else                   dma_wait = 0;
        own = 0;
        e_data = '0;
        if (e_rd) begin
            own    = e_dma ? 2 : 1;
            e_data = ref_word(e_addr);
        end
        if (e_wr) ref_write(e_addr, e_din, e_sz);
        @(negedge clk);
        check_eq("cpu_rvalid", cpu_rvalid, own == 1);
        check_eq("dma_rvalid", dma_rvalid, own == 2);
        if (own == 1) check_eq("cpu_rdata", cpu_rdata, e_data);
        if (own == 2) check_eq("dma_rdata", dma_rdata, e_data);
    endtask

    task automatic rand_txn(output logic w, output logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] s, output logic sg);
        logic [9:0] off;
        w   = ($urandom_range(0, 2) == 0);
        s   = 2'($urandom_range(0, 2));
        off = 10'($urandom_range(0, 1023));
        if (s == 2'd1) off[0] = 1'b0;
        if (s == 2'd2) off[1:0] = 2'b00;
        a   = {($urandom_range(0, 3) == 0) ? 8'h11 : 8'h00, 14'd0, off};
        d   = $urandom;
        sg  = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic        w, sg;
        logic [31:0] a, d;
        logic [1:0]  s;

        rst_n    = 1'b0;
        mem_init = 1'b1;
        dma_wait = 0;
        set_cpu(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        for (int i = 0; i < 256; i++) begin
            d = init_word(i);
            for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = d[8*k +: 8];
        end

        // Reset state: no grants or strobes even with a request pending
        @(negedge clk);
        mem_init = 1'b0;
        #1;
        check_eq("rst_cpu_gnt", cpu_gnt, 1'b0);
        check_eq("rst_mem_read2", mem_read2, 1'b0);
        check_eq("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        check_eq("rst_dma_rvalid", dma_rvalid, 1'b0);
        cpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // CPU-only word load from 0x100
        set_cpu(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        step();
        check_eq("t1_rdata", cpu_rdata, 32'h12345678);

        // CPU store then DMA load of the same address on the next cycle
        set_cpu(1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 2'd2, 1'b0);
        step();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        set_dma(1'b1, 1'b0, 32'h200, 32'h0, 2'd2, 1'b0);
        step();
        check_eq("t3_dma_rdata", dma_rdata, 32'hDEADBEEF);

        // Alternating owners back to back
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        step();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        set_dma(1'b1, 1'b0, 32'h14, 32'h0, 2'd2, 1'b0);
        step();
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        set_cpu(1'b1, 1'b0, 32'h18, 32'h0, 2'd2, 1'b0);
        step();
        check_eq("t4_cpu_word", cpu_rdata, init_word(6));

        // Both requesting continuously: DMA forced in every fifth cycle
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        step();
        set_cpu(1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
        set_dma(1'b1, 1'b0, 32'h44, 32'h0, 2'd2, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            step();
            check_eq("t2_dma_slot", obs_dma_gnt, (i % 5) == 0);
            check_eq("t2_one_hot", obs_cpu_gnt & obs_dma_gnt, 1'b0);
        end

        // Reset right after a CPU read grant with starvation partly built up
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        step();
        set_cpu(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        set_dma(1'b1, 1'b0, 32'h80, 32'h0, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) step();
        #1;
        check_eq("t5_cpu_gnt", cpu_gnt, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_gnt", cpu_gnt | dma_gnt, 1'b0);
        check_eq("t5_rst_strobe", mem_read2 | mem_write2, 1'b0);
        @(negedge clk);
        check_eq("t5_cpu_rvalid", cpu_rvalid, 1'b0);
        check_eq("t5_dma_rvalid", dma_rvalid, 1'b0);
        rst_n    = 1'b1;
        dma_wait = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_eq("t5_dma_slot", obs_dma_gnt, i == 5);
        end
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        step();
        check_eq("t5_dma_only", obs_dma_gnt, 1'b1);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
        step();

        // Random traffic; each requester holds its fields until granted
        for (int n = 0; n < 400; n++) begin
            if (!cpu_req && ($urandom_range(0, 99) < 60)) begin
                rand_txn(w, a, d, s, sg);
                set_cpu(1'b1, w, a, d, s, sg);
            end
            if (!dma_req && ($urandom_range(0, 99) < 60)) begin
                rand_txn(w, a, d, s, sg);
                set_dma(1'b1, w, a, d, s, sg);
            end
            step();
            check_eq("rnd_one_hot", obs_cpu_gnt & obs_dma_gnt, 1'b0);
            if (g_cpu) cpu_req = 1'b0;
            if (g_dma) dma_req = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
